// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues credit-limited imem requests, buffers words for decode.
// Optional macro FETCH_MISALIGN_TRAP_EN adds fetch_misaligned and a HALT state on misaligned redirect.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misaligned
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_RESET, S_RUN, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_RESET, S_RUN} state_t;
`endif

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc;
    logic [CW-1:0]   buf_cnt, out_cnt, discard_cnt, out_next;
    logic [CW:0]     inflight;
    logic [31:0]     pcq_mem [DEPTH];
    logic [PW-1:0]   pcq_wp, pcq_rp;
    logic [31:0]     buf_instr [DEPTH];
    logic [31:0]     buf_pc [DEPTH];
    logic [PW-1:0]   buf_wp, buf_rp;
    logic            req_fire, take_redirect, push, pop, trap;

    always_comb begin
        state_d        = state_q;
        trap           = 1'b0;
        take_redirect  = redirect && (state_q == S_RUN);
`ifdef FETCH_MISALIGN_TRAP_EN
        trap           = take_redirect && (redirect_pc[1:0] != 2'b00);
`endif
        case (state_q)
            S_RESET: state_d = S_RUN;
            S_RUN:   if (trap) state_d = state_t'(2);
            default: state_d = state_q;
        endcase

        // Credit check uses registered counts only, so no input reaches imem_req_valid.
        inflight       = {1'b0, buf_cnt} + {1'b0, out_cnt};
        imem_req_valid = (state_q == S_RUN) && (inflight < DEPTH_C);
        req_fire       = imem_req_valid && imem_req_ready;
        push           = imem_rsp_valid && (discard_cnt == '0) && !take_redirect;
        instr_valid    = (state_q == S_RUN) && (buf_cnt != '0);
        pop            = instr_valid && instr_ready && !take_redirect;
        out_next       = out_cnt + CW'(req_fire) - CW'(imem_rsp_valid);
    end

    assign imem_req_addr  = fetch_pc;
    assign instr          = buf_instr[buf_rp];
    assign instr_pc       = buf_pc[buf_rp];
    assign instr_pc_plus4 = instr_pc + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_RESET;
            fetch_pc    <= RESET_PC;
            buf_cnt     <= '0;
            out_cnt     <= '0;
            discard_cnt <= '0;
            pcq_wp      <= '0;
            pcq_rp      <= '0;
            buf_wp      <= '0;
            buf_rp      <= '0;
        end else begin
            state_q <= state_d;
            out_cnt <= out_next;
            pcq_wp  <= pcq_wp + PW'(req_fire);
            pcq_rp  <= pcq_rp + PW'(imem_rsp_valid);
            if (take_redirect) begin
                // Everything still in flight after this edge belongs to the old path.
                fetch_pc    <= redirect_pc & 32'hFFFF_FFFC;
                discard_cnt <= out_next;
                buf_cnt     <= '0;
                buf_wp      <= '0;
                buf_rp      <= '0;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (imem_rsp_valid && (discard_cnt != '0))
                    discard_cnt <= discard_cnt - CW'(1);
                buf_cnt <= buf_cnt + CW'(push) - CW'(pop);
                buf_wp  <= buf_wp + PW'(push);
                buf_rp  <= buf_rp + PW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            pcq_mem[pcq_wp] <= fetch_pc;
    end

    // Buffer storage is reset so decode sees instr=0 / instr_pc=0 out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else begin
            if (push) begin
                buf_instr[buf_wp] <= imem_rsp_data;
                buf_pc[buf_wp]    <= pcq_mem[pcq_rp];
            end
            if (trap)
                buf_pc[0] <= redirect_pc;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fetch_misaligned <= 1'b0;
        else if (trap)
            fetch_misaligned <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed steps plus a random phase, memory model and word scoreboard.
module tb_instr_fetch;

    localparam int DEPTH = 2;

    logic        clk, reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc, instr_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misaligned;
`endif

    instr_fetch #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        int          acc;
        bit          stale;
    } req_t;

    req_t        pend[$];
    logic [31:0] expq[$];
    logic [31:0] exp_fpc;
    int          nvec, nerr, cyc, nacc;
    bit          req_ready_g, iready_g, mem_stall;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check, then advance the model.
    task automatic step(input bit redir, input logic [31:0] rpc);
        req_t        e;
        logic [31:0] p;
        bit          rfire, pfire, rsp;
        @(negedge clk);
        imem_req_ready = req_ready_g;
        instr_ready    = iready_g;
        redirect       = redir;
        redirect_pc    = rpc;
        rsp            = !mem_stall && (pend.size() > 0) && (pend[0].acc < cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? memfn(pend[0].addr) : 32'h0;
        #1;
        chk("instr_valid", {31'h0, instr_valid}, {31'h0, expq.size() != 0});
        chk("req_valid", {31'h0, imem_req_valid}, {31'h0, (expq.size() + pend.size()) < DEPTH});
        if (imem_req_valid)
            chk("req_addr", imem_req_addr, exp_fpc);
        rfire = imem_req_valid && imem_req_ready;
        pfire = instr_valid && instr_ready && !redir;
        if (pfire && expq.size() > 0) begin
            p = expq.pop_front();
            chk("instr_pc", instr_pc, p);
            chk("instr", instr, memfn(p));
            chk("instr_pc_plus4", instr_pc_plus4, p + 32'd4);
        end
        if (rsp) begin
            e = pend.pop_front();
            if (!e.stale && !redir)
                expq.push_back(e.pc);
        end
        if (rfire) begin
            e.pc    = exp_fpc;
            e.addr  = imem_req_addr;
            e.acc   = cyc;
            e.stale = 1'b0;
            pend.push_back(e);
            exp_fpc = exp_fpc + 32'd4;
            nacc++;
        end
        if (redir) begin
            foreach (pend[i]) pend[i].stale = 1'b1;
            expq.delete();
            exp_fpc = rpc & 32'hFFFF_FFFC;
        end
        cyc++;
    endtask

    task automatic wait_valid(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            step(1'b0, 32'h0);
            ok = instr_valid;
        end
        chk({tag, "_timeout"}, {31'h0, ok}, 32'h1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_req_valid"}, {31'h0, imem_req_valid}, 32'h0);
        chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
        chk({tag, "_instr_valid"}, {31'h0, instr_valid}, 32'h0);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_instr_pc"}, instr_pc, 32'h0);
        chk({tag, "_pc_plus4"}, instr_pc_plus4, 32'h4);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk({tag, "_misaligned"}, {31'h0, fetch_misaligned}, 32'h0);
`endif
    endtask

    task automatic fill_two_outstanding();
        mem_stall = 1'b1;
        for (int k = 0; k < 10 && pend.size() != 2; k++)
            step(1'b0, 32'h0);
        chk("two_outstanding", pend.size(), 32'd2);
    endtask

    initial begin
        logic [31:0] a0;
        int          n0;
        bit          found;
        nvec = 0; nerr = 0; cyc = 0; nacc = 0;
        reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
        req_ready_g = 1'b1; iready_g = 1'b1; mem_stall = 1'b0;
        exp_fpc = 32'h0;
        repeat (2) @(negedge clk);
        #1 check_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;

        // Streaming with ready memory and decode
        repeat (20) step(1'b0, 32'h0);

        // Decode backpressure
        iready_g = 1'b0;
        n0 = nacc;
        repeat (10) step(1'b0, 32'h0);
        chk("bp_accept_limit", {31'h0, (nacc - n0) <= DEPTH}, 32'h1);
        chk("bp_req_dropped", {31'h0, imem_req_valid}, 32'h0);
        iready_g = 1'b1;
        repeat (10) step(1'b0, 32'h0);

        // Memory not ready: address held
        req_ready_g = 1'b0;
        step(1'b0, 32'h0);
        a0 = imem_req_addr;
        repeat (3) step(1'b0, 32'h0);
        chk("stall_addr_held", imem_req_addr, a0);
        req_ready_g = 1'b1;
        repeat (5) step(1'b0, 32'h0);

        // Redirect with two outstanding
        fill_two_outstanding();
        step(1'b1, 32'h100);
        mem_stall = 1'b0;
        wait_valid("redir100");
        chk("redir100_pc", instr_pc, 32'h100);
        repeat (8) step(1'b0, 32'h0);

        // Second redirect while discards pending
        fill_two_outstanding();
        step(1'b1, 32'h300);
        mem_stall = 1'b0;
        step(1'b0, 32'h0);
        step(1'b1, 32'h400);
        wait_valid("redir400");
        chk("redir400_pc", instr_pc, 32'h400);
        repeat (8) step(1'b0, 32'h0);

`ifndef FETCH_MISALIGN_TRAP_EN
        step(1'b1, 32'h203);
        wait_valid("redir203");
        chk("redir203_pc", instr_pc, 32'h200);
        repeat (5) step(1'b0, 32'h0);
`endif

        // PC wraparound
        step(1'b1, 32'hFFFF_FFF8);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1'b0, 32'h0);
            found = instr_valid && (instr_pc == 32'hFFFF_FFFC);
        end
        chk("wrap_found", {31'h0, found}, 32'h1);
        chk("wrap_plus4", instr_pc_plus4, 32'h0);
        repeat (6) step(1'b0, 32'h0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            req_ready_g = ($urandom_range(0, 3) != 0);
            iready_g    = ($urandom_range(0, 3) != 0);
            mem_stall   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0)
                step(1'b1, $urandom & 32'h0000_FFFC);
            else
                step(1'b0, 32'h0);
        end
        req_ready_g = 1'b1; iready_g = 1'b1; mem_stall = 1'b0;
        repeat (20) step(1'b0, 32'h0);

        // Reset in the middle of operation
        #2 reset = 1'b1;
        redirect = 1'b0; imem_rsp_valid = 1'b0;
        #1 check_reset_state("midreset");
        pend.delete(); expq.delete(); exp_fpc = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        repeat (15) step(1'b0, 32'h0);

`ifdef FETCH_MISALIGN_TRAP_EN
        step(1'b1, 32'h102);
        @(negedge clk);
        redirect = 1'b0; imem_rsp_valid = 1'b0;
        #1;
        chk("trap_flag", {31'h0, fetch_misaligned}, 32'h1);
        chk("trap_pc", instr_pc, 32'h102);
        for (int k = 0; k < 4; k++) begin
            chk("trap_req_valid", {31'h0, imem_req_valid}, 32'h0);
            chk("trap_instr_valid", {31'h0, instr_valid}, 32'h0);
            @(negedge clk);
            #1;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the RISC-V core. It sits directly upstream of decode and the immediate extender. It owns the program counter, issues in-order word requests to instruction memory through a credit-limited request/response interface, and buffers returned words in a small FIFO. Each word is delivered with its PC and PC+4 over a valid/ready handshake. A redirect from the branch/jump target adder (PC + ImmExt) flushes the buffer, discards in-flight responses and restarts fetch at the new target.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, buffer entries and maximum outstanding-plus-buffered words (power of two, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word address of request, bits [1:0]=0
- imem_rsp_valid  in  1  response valid; in order, ≥1 cycle after acceptance, no backpressure
- imem_rsp_data  in  32  returned instruction word
- redirect  in  1  take new PC (taken branch / jal / jalr)
- redirect_pc  in  32  new fetch target (PCTarget)
- instr_valid  out  1  instr/instr_pc valid to decode
- instr_ready  in  1  decode consumes
- instr  out  32  instruction word; Instr[31:7] feeds the immediate extender
- instr_pc  out  32  PC of instr
- instr_pc_plus4  out  32  instr_pc + 4, modulo 2^32

## Operation
- Counters: fetch_pc (32b), buf_cnt, out_cnt, discard_cnt; each count is $clog2(DEPTH)+1 bits wide.
- Issue rule: imem_req_valid = (state==RUN) && (buf_cnt + out_cnt < DEPTH). The sum uses registered values only.
- Request accepted (valid && ready): fetch_pc += 4 (wraps 32'hFFFF_FFFC→0), out_cnt++. Each accepted PC is recorded in the PC FIFO alongside its slot.
- While valid && !ready: imem_req_addr is held stable. The only exception is the cycle after a redirect.
- Response: out_cnt--. If discard_cnt>0, the word is dropped and discard_cnt--. Otherwise it is pushed into the buffer with its PC.
- Pop: instr_valid && instr_ready removes the head entry.
- Redirect (registered, takes effect next edge):
  - fetch_pc ← {redirect_pc[31:2],2'b00}.
  - Buffer cleared, buf_cnt←0.
  - discard_cnt ← out_cnt + (request accepted this cycle) − (response this cycle).
  - A pop in the same cycle is ignored.
  - A redirect asserted while a previous discard is still pending accumulates correctly.
- States: RUN, HALT (HALT exists only with the macro, see Configuration). RESET→RUN on reset release.
- Simultaneous push+pop with the buffer full: both succeed and buf_cnt is unchanged.

## Timing
- Reset values:
  - imem_req_valid=0, imem_req_addr=RESET_PC
  - instr_valid=0, instr=0, instr_pc=0, instr_pc_plus4=4
  - fetch_pc=RESET_PC, all counts 0
- First edge after reset release: imem_req_valid=1 with addr=RESET_PC.
- All outputs are driven from registers. There is no combinational path from any input to any output.
- Latency: a response at cycle t gives instr_valid=1 at t+1 (one buffer write cycle).
- Redirect at cycle t: the request at t+1 carries the new address. No stale word is ever presented after t.
- Reset asserted mid-operation: immediate clear. Responses arriving after reset release are not expected; memory is reset together with this block.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - Adds output fetch_misaligned (1b, reset 0).
  - A redirect with redirect_pc[1:0]≠0 sets fetch_misaligned=1, stores redirect_pc in instr_pc, flushes as normal, and enters HALT.
  - HALT: no requests are issued and instr_valid=0 until reset.
- Undefined: redirect_pc[1:0] is ignored (forced to 00), there is no HALT state, and the port is absent.

## Test plan
- Reset release, imem_req_ready=1, 1-cycle memory, instr_ready=1 → words from addresses 0,4,8,… appear in order with instr_pc=0,4,8 and instr_pc_plus4=4,8,12.
- instr_ready=0 for 10 cycles → at most DEPTH=2 requests accepted, imem_req_valid drops, no response lost, order preserved when ready returns.
- imem_req_ready=0 for 3 cycles → imem_req_addr held at same value, fetch_pc not advanced.
- Redirect to 32'h100 with 2 requests outstanding → both responses dropped, next presented word has instr_pc=32'h100.
- fetch_pc=32'hFFFF_FFFC accepted → next request addr 32'h0, instr_pc_plus4 of that word = 0.
- FETCH_MISALIGN_TRAP_EN: redirect_pc=32'h102 → fetch_misaligned=1, instr_pc=32'h102, no further imem_req_valid until reset.
